// File: rtl/dot_product_pkg.sv
// Shared encodings and default widths for the dot-product sequencer and its bench.
package dot_product_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int ACC_WIDTH_DEF  = 2 * DATA_WIDTH_DEF + ADDR_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_accumulator.sv
// Registered unsigned multiply-accumulate with synchronous clear; wraps modulo 2**ACC_WIDTH.
module mac_accumulator
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]    w_prod_ext;

    assign w_prod     = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, w_prod};

    // Accumulator: clear has priority over a pending product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= {ACC_WIDTH{1'b0}};
        end else if (clr) begin
            acc <= {ACC_WIDTH{1'b0}};
        end else if (en) begin
            acc <= acc + w_prod_ext;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams len operand pairs from two memories, accumulates the
// products and offers the sum on a valid/ready port.
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

    state_t               r_state;
    logic [ADDR_WIDTH:0]  r_left;
    logic                 r_rd_v;
    logic                 w_clr;
    logic [ACC_WIDTH-1:0] w_acc;

    // The accumulator is cleared on the same edge that accepts a command.
    assign w_clr = (r_state == ST_IDLE) && start;

    mac_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (r_rd_v),
        .a     (rd_data_a),
        .b     (rd_data_b),
        .acc   (w_acc)
    );

    // Sequencer FSM with registered outputs; r_left counts reads still to issue after this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_left       <= CNT_ZERO;
            r_rd_v       <= 1'b0;
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr_a    <= {ADDR_WIDTH{1'b0}};
            rd_addr_b    <= {ADDR_WIDTH{1'b0}};
            result       <= {ACC_WIDTH{1'b0}};
            result_valid <= 1'b0;
        end else begin
            r_rd_v <= rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        rd_addr_a <= base_a;
                        rd_addr_b <= base_b;
                        if (len == CNT_ZERO) begin
                            r_state <= ST_DONE;
                            r_left  <= CNT_ZERO;
                            rd_en   <= 1'b0;
                        end else begin
                            r_state <= ST_READ;
                            r_left  <= len - CNT_ONE;
                            rd_en   <= 1'b1;
                        end
                    end else begin
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (r_left == CNT_ZERO) begin
                        rd_en   <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_left    <= r_left - CNT_ONE;
                        rd_addr_a <= rd_addr_a + ADDR_ONE;
                        rd_addr_b <= rd_addr_b + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        result_valid <= 1'b1;
                        result       <= w_acc;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    busy         <= 1'b0;
                    rd_en        <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench: directed and random commands against an arithmetic reference.
module tb_dot_product_ctrl;
    import dot_product_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;
    localparam int AW = ADDR_WIDTH_DEF;
    localparam int CW = ACC_WIDTH_DEF;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic [AW-1:0] base_a, base_b;
    logic          busy, rd_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    int n_chk = 0;
    int n_err = 0;

    dot_product_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .base_a       (base_a),
        .base_b       (base_b),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Operand memories with a one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_dot(input int n, input int ba, input int bb);
        longint s = 0;
        for (int i = 0; i < n; i++)
            s += longint'(mem_a[(ba + i) % DEPTH]) * longint'(mem_b[(bb + i) % DEPTH]);
        return 32'(s % (longint'(1) << CW));
    endfunction

    // Issue one command, check addresses, latency and result, then the handshake.
    task automatic run_cmd(input int n, input int ba, input int bb, input logic [31:0] exp,
                           input int hold);
        int edges = 0;
        int reads = 0;
        bit seen = 0;
        logic [CW-1:0] held;
        @(negedge clk);
        start = 1'b1; len = (AW+1)'(n); base_a = AW'(ba); base_b = AW'(bb);
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && edges < 60) begin
            if (rd_en) begin
                check_eq("addr_a", 32'(rd_addr_a), 32'((ba + reads) % DEPTH));
                check_eq("addr_b", 32'(rd_addr_b), 32'((bb + reads) % DEPTH));
                reads++;
            end
            if (result_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                edges++;
            end
        end
        check_eq("latency", 32'(edges), 32'((n == 0) ? 1 : n + 2));
        check_eq("reads", 32'(reads), 32'(n));
        if (!seen) return;
        check_eq("result", 32'(result), exp);
        check_eq("busy_done", 32'(busy), 32'd1);
        held = result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = (h % 3 == 0);
            result_ready = 1'b0;
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(result_valid), 32'd1);
            check_eq("hold_result", 32'(result), 32'(held));
        end
        @(negedge clk);
        result_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check_eq("accept_valid", 32'(result_valid), 32'd0);
        check_eq("accept_busy", 32'(busy), 32'd0);
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid", 32'(result_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; base_a = '0; base_b = '0;
        result_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(rd_en), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        run_cmd(4, 0, 0, 32'd70, 0);
        run_cmd(0, 5, 9, 32'd0, 0);

        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        run_cmd(16, 7, 2, 32'd1040400, 0);

        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
        run_cmd(4, 14, 3, ref_dot(4, 14, 3), 0);
        run_cmd(5, 2, 11, ref_dot(5, 2, 11), 10);

        // Abort mid-read: outputs must clear without waiting for a clock edge.
        @(negedge clk);
        start = 1'b1; len = 5'd8; base_a = 4'd0; base_b = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_addr", 32'(rd_addr_a), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rd_en", 32'(rd_en), 32'd0);
        check_eq("abort_addr_a", 32'(rd_addr_a), 32'd0);
        check_eq("abort_addr_b", 32'(rd_addr_b), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_no_valid", 32'(result_valid), 32'd0);
        run_cmd(2, 9, 4, ref_dot(2, 9, 4), 0);

        for (int k = 0; k < 6; k++) begin
            int n, ba, bb;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] = 8'($urandom);
                mem_b[i] = 8'($urandom);
            end
            n  = $urandom_range(0, DEPTH);
            ba = $urandom_range(0, DEPTH - 1);
            bb = $urandom_range(0, DEPTH - 1);
            run_cmd(n, ba, bb, ref_dot(n, ba, bb), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
